// File: rtl/input_port_ctrl.sv
// input_port_ctrl
//   Per-port input controller for a mesh router. Incoming flits are buffered
//   in a small FIFO. The header at the FIFO head is decoded to an XY output
//   direction, a switch-allocator request is held for the whole packet, and
//   the packet's flits are streamed to the crossbar. A body-flit countdown
//   marks the tail, so the next header is found without any external framing.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   in_valid     upstream flit valid
//   in_ready     FIFO can accept (not full)
//   in_data      upstream flit
//   route_req    one-hot request {L,W,S,E,N}
//   route_grant  allocator grant for the current request (level)
//   out_valid    flit presented to crossbar
//   out_ready    crossbar accepts flit
//   out_data     flit to crossbar (FIFO head)
//   out_head     out_data is a header flit
//   out_tail     out_data is the last flit of its packet
//
// FSM states
//   state   | meaning
//   IDLE    | waiting for a header at the FIFO head
//   ROUTE   | requesting route_dir from the allocator, waiting for grant
//   FORWARD | streaming header and body flits to the crossbar

module input_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_WIDTH   = 8,
    parameter int COORD_WIDTH = 4,
    parameter int DEPTH       = 4,
    parameter int LOCAL_X     = 0,
    parameter int LOCAL_Y     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [4:0]            route_req,
    input  logic                  route_grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_head,
    output logic                  out_tail
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]         FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [COORD_WIDTH-1:0] LX       = COORD_WIDTH'(LOCAL_X);
    localparam logic [COORD_WIDTH-1:0] LY       = COORD_WIDTH'(LOCAL_Y);

    localparam logic [4:0] DIR_N = 5'b00001;
    localparam logic [4:0] DIR_E = 5'b00010;
    localparam logic [4:0] DIR_S = 5'b00100;
    localparam logic [4:0] DIR_W = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    typedef enum logic [1:0] {IDLE, ROUTE, FORWARD} state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_flit;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign in_ready  = !full;
    // Push is gated by full alone: a pop in the same cycle does not free a slot.
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;
    assign head_flit = mem[rd_ptr];

    // Storage has no reset; emptying the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Header decode and XY routing (X resolved first, unsigned compares)
    // ------------------------------------------------------------------
    logic [COORD_WIDTH-1:0] dest_x;
    logic [COORD_WIDTH-1:0] dest_y;
    logic [4:0]             dir;

    assign dest_y = head_flit[ADD_WIDTH +: COORD_WIDTH];
    assign dest_x = head_flit[ADD_WIDTH+COORD_WIDTH +: COORD_WIDTH];

    always_comb begin
        dir = DIR_L;
        if (dest_x > LX) begin
            dir = DIR_E;
        end else if (dest_x < LX) begin
            dir = DIR_W;
        end else if (dest_y > LY) begin
            dir = DIR_N;
        end else if (dest_y < LY) begin
            dir = DIR_S;
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    state_t               state;
    logic [ADD_WIDTH-1:0] remaining;
    logic                 first;  // next transfer in FORWARD is the header

    assign out_valid = (state == FORWARD) && !empty;
    assign out_data  = head_flit;
    assign out_head  = out_valid && first;
    assign out_tail  = out_valid && (first ? (remaining == '0)
                                           : (remaining == ADD_WIDTH'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            route_req <= '0;
            remaining <= '0;
            first     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        route_req <= dir;
                        remaining <= head_flit[ADD_WIDTH-1:0];
                        first     <= 1'b1;
                        state     <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (route_grant) begin
                        state <= FORWARD;
                    end
                end
                FORWARD: begin
                    if (pop) begin
                        first <= 1'b0;
                        if (!first) begin
                            remaining <= remaining - 1'b1;
                        end
                        if (out_tail) begin
                            route_req <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    route_req <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl with LOCAL_X = LOCAL_Y = 2, DEPTH = 4.
// Inputs change and outputs are sampled shortly after the falling edge.

module tb_input_port_ctrl;

    localparam int DW = 32;

    localparam logic [4:0] R_N = 5'b00001;
    localparam logic [4:0] R_E = 5'b00010;
    localparam logic [4:0] R_S = 5'b00100;
    localparam logic [4:0] R_W = 5'b01000;
    localparam logic [4:0] R_L = 5'b10000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [4:0]    route_req;
    logic          route_grant = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_head;
    logic          out_tail;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fl [0:259];
    bit            fh [0:259];
    bit            ft [0:259];
    int            xfer_it [0:259];
    logic [4:0]    rr_log [0:299];

    always #5 clk = ~clk;

    input_port_ctrl #(
        .DATA_WIDTH (32),
        .ADD_WIDTH  (8),
        .COORD_WIDTH(4),
        .DEPTH      (4),
        .LOCAL_X    (2),
        .LOCAL_Y    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .route_req  (route_req),
        .route_grant(route_grant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_head   (out_head),
        .out_tail   (out_tail)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int x, input int y, input int len);
        return {16'h0, 4'(x), 4'(y), 8'(len)};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 260; i++) begin
            fl[i]      = '0;
            fh[i]      = 1'b0;
            ft[i]      = 1'b0;
            xfer_it[i] = -1;
        end
        for (int i = 0; i < 300; i++) rr_log[i] = '0;
    endtask

    // Single-flit packet: header push, request at push+2, optional wait in
    // ROUTE, then one head+tail transfer and back to IDLE.
    task automatic route_one(input int x, input int y, input logic [4:0] exp_dir, input int waitc);
        push(hdr(x, y, 0));
        chk("rt_idle_t1", 32'(route_req), 32'(0));
        tick();
        chk($sformatf("rt_req_%0d_%0d", x, y), 32'(route_req), 32'(exp_dir));
        chk("rt_no_valid_in_route", 32'(out_valid), 32'(0));
        for (int i = 0; i < waitc; i++) begin
            tick();
            chk("rt_req_held", 32'(route_req), 32'(exp_dir));
        end
        route_grant = 1'b1;
        tick();
        route_grant = 1'b0;
        chk("rt_fwd_valid", 32'(out_valid), 32'(1));
        chk("rt_fwd_head", 32'(out_head), 32'(1));
        chk("rt_fwd_tail", 32'(out_tail), 32'(1));
        chk("rt_fwd_data", out_data, hdr(x, y, 0));
        tick();
        chk("rt_after_req", 32'(route_req), 32'(0));
        chk("rt_after_valid", 32'(out_valid), 32'(0));
    endtask

    // Drives fl[0..n-1] upstream and checks every crossbar transfer against
    // fl/fh/ft. out_ready is held low for the first 'hold' cycles.
    task automatic stream(input int n, input int hold, input int maxc);
        int p = 0;
        int k = 0;
        for (int c = 0; c < maxc && k < n; c++) begin
            in_valid  = (p < n);
            in_data   = fl[(p < n) ? p : 0];
            out_ready = (c >= hold);
            #1;
            if (c < 300) rr_log[c] = route_req;
            if (c < hold) begin
                // no pops yet, so FIFO occupancy equals pushes so far
                chk("bp_in_ready", 32'(in_ready), 32'(p < 4));
            end
            if (out_valid && !out_ready) begin
                chk("bp_hold_data", out_data, fl[k]);
                chk("bp_hold_head", 32'(out_head), 32'(fh[k]));
                chk("bp_hold_tail", 32'(out_tail), 32'(ft[k]));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("xfer_data_%0d", k), out_data, fl[k]);
                chk($sformatf("xfer_head_%0d", k), 32'(out_head), 32'(fh[k]));
                chk($sformatf("xfer_tail_%0d", k), 32'(out_tail), 32'(ft[k]));
                xfer_it[k] = c;
                k++;
            end
            if (in_valid && in_ready) p++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_xfer_count", k, n);
    endtask

    initial begin
        int e;
        clear_tables();

        // Reset state
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_route_req", 32'(route_req), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Reset mid-FORWARD with 3 flits buffered
        route_grant = 1'b1;
        out_ready   = 1'b0;
        push(hdr(3, 0, 5));
        push(32'hA000_0001);
        push(32'hA000_0002);
        chk("mid_fwd_valid", 32'(out_valid), 32'(1));
        chk("mid_fwd_req", 32'(route_req), 32'(R_E));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(route_req), 32'(0));
        chk("async_rst_valid", 32'(out_valid), 32'(0));
        tick();
        reset       = 1'b1;
        route_grant = 1'b0;
        out_ready   = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_valid", 32'(out_valid), 32'(0));
        chk("post_rst_req", 32'(route_req), 32'(0));
        route_one(1, 3, R_W, 0);

        // XY routing from (2,2)
        route_one(3, 0, R_E, 0);
        route_one(1, 3, R_W, 0);
        route_one(2, 3, R_N, 0);
        route_one(2, 0, R_S, 0);
        route_one(2, 2, R_L, 0);

        // Single-flit packet, grant three cycles after the request
        route_one(3, 3, R_E, 3);

        // L = 5 under backpressure for 10 cycles
        clear_tables();
        fl[0] = hdr(3, 0, 5);
        fh[0] = 1'b1;
        for (int i = 1; i <= 5; i++) fl[i] = 32'hB000_0000 + 32'(i);
        ft[5] = 1'b1;
        route_grant = 1'b1;
        stream(6, 10, 60);
        route_grant = 1'b0;
        chk("l5_idle_req", 32'(route_req), 32'(0));
        chk("l5_idle_valid", 32'(out_valid), 32'(0));

        // Back-to-back packets L = 2 then L = 1, grant held
        clear_tables();
        fl[0] = hdr(1, 3, 2);
        fh[0] = 1'b1;
        fl[1] = 32'hC100_0001;
        fl[2] = 32'hC100_0002;
        ft[2] = 1'b1;
        fl[3] = hdr(2, 3, 1);
        fh[3] = 1'b1;
        fl[4] = 32'hC200_0001;
        ft[4] = 1'b1;
        route_grant = 1'b1;
        stream(5, 0, 40);
        route_grant = 1'b0;
        e = xfer_it[2];
        if (e >= 0 && e + 2 < 300) begin
            chk("b2b_idle_req", 32'(rr_log[e+1]), 32'(0));
            chk("b2b_req_again", 32'(rr_log[e+2]), 32'(R_N));
        end else begin
            chk("b2b_tail_seen", e, 32'(0));
        end
        chk("b2b_head_latency", xfer_it[3], e + 3);

        // Maximum length L = 255
        clear_tables();
        fl[0] = hdr(2, 0, 255);
        fh[0] = 1'b1;
        for (int i = 1; i <= 255; i++) fl[i] = 32'hD000_0000 + 32'(i);
        ft[255] = 1'b1;
        route_grant = 1'b1;
        stream(256, 0, 400);
        route_grant = 1'b0;
        chk("l255_idle_req", 32'(route_req), 32'(0));
        chk("l255_idle_valid", 32'(out_valid), 32'(0));
        tick();
        chk("l255_no_extra", 32'(out_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_port_ctrl.md
# input_port_ctrl

Per-port input controller for the mesh router. It buffers incoming flits, decodes the header flit of each packet, and computes an XY output direction. It then holds a switch-allocator request for the duration of the packet and streams the packet's flits to the crossbar. It also tracks the packet's body-flit count so the next header is recognised without external help.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width; must be ≥ ADD_WIDTH + 2*COORD_WIDTH
- ADD_WIDTH, 8, width of the header length field (body flit count)
- COORD_WIDTH, 4, width of each destination coordinate
- DEPTH, 4, input FIFO entries; power of 2, ≥ 2
- LOCAL_X, 0, this router's X coordinate
- LOCAL_Y, 0, this router's Y coordinate

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream flit valid
- in_ready  out  1  FIFO can accept; equals !full
- in_data  in  DATA_WIDTH  upstream flit
- route_req  out  5  one-hot request {L,W,S,E,N} = bits [4:0]
- route_grant  in  1  allocator grant for the current request (level)
- out_valid  out  1  flit presented to crossbar
- out_ready  in  1  crossbar accepts flit
- out_data  out  DATA_WIDTH  flit to crossbar (FIFO head)
- out_head  out  1  out_data is a header flit
- out_tail  out  1  out_data is the last flit of its packet

## Operation
- Header format:
  - [ADD_WIDTH-1:0] = L, the number of body flits that follow (0..2^ADD_WIDTH-1).
  - [ADD_WIDTH+COORD_WIDTH-1:ADD_WIDTH] = dest_y.
  - Next COORD_WIDTH bits = dest_x.
  - Upper bits are ignored.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - No push while full, even if a pop occurs the same cycle (no bypass).
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ROUTE, FORWARD.
- IDLE:
  - When the FIFO is non-empty, its head is a header.
  - Latch route_dir from the head header, latch remaining = L, and go to ROUTE.
- XY routing (unsigned compares):
  - dest_x > LOCAL_X → E.
  - dest_x < LOCAL_X → W.
  - Otherwise, dest_y > LOCAL_Y → N.
  - Otherwise, dest_y < LOCAL_Y → S.
  - Otherwise → L.
- ROUTE:
  - route_req = route_dir.
  - Stay until route_grant = 1 is sampled, then go to FORWARD.
  - route_grant is ignored in IDLE and FORWARD.
- FORWARD:
  - route_req is held at route_dir.
  - out_valid = !empty.
  - First transfer is the header (out_head = 1).
  - Each body transfer decrements remaining.
  - out_tail = 1 on the header when L = 0, or on the body flit when remaining = 1.
  - A transfer with out_tail = 1 returns the FSM to IDLE.
- Outputs in IDLE/ROUTE: out_valid, out_head and out_tail = 0. route_req = 0 in IDLE.
- Packet integrity: upstream flits arriving mid-packet are buffered; they never alter route_dir or remaining.

## Timing
- Reset (async assert): FIFO emptied and contents discarded; state = IDLE; route_req = 0; out_valid = 0; remaining = 0. in_ready = 1 from the first cycle after reset.
- Header pushed at edge t:
  - Visible in the FIFO at t+1 (IDLE sees non-empty).
  - ROUTE entered at t+2, route_req asserted from t+2.
- Grant sampled high at edge g: FORWARD from g+1, header on out_data with out_valid = 1 at g+1.
- Throughput: one flit per cycle in FORWARD while the FIFO is non-empty and out_ready = 1.
- Tail transfer at edge e:
  - IDLE at e+1 with route_req = 0.
  - Next header earliest in ROUTE at e+2 (one mandatory idle cycle between packets).
- Backpressure: out_ready = 0 holds out_data, out_head and out_tail stable.
- Reset mid-packet: the packet is aborted, no tail is emitted, and the next flit after reset is treated as a header.
- Simultaneous push and pop, not full: count is unchanged and both take effect.

## Test plan
- Reset: assert reset mid-FORWARD with 3 flits buffered → route_req = 0, out_valid = 0, in_ready = 1 after release. The next pushed flit is decoded as a header.
- Routing (LOCAL_X = 2, LOCAL_Y = 2): headers to (3,0), (1,3), (2,3), (2,0), (2,2) → route_req = E, W, N, S, L respectively, each at header push + 2.
- Single-flit packet (L = 0): push header, grant after 3 cycles → one transfer with out_head = out_tail = 1, then IDLE, route_req drops.
- L = 5 with DEPTH = 4, out_ready = 0 for 10 cycles:
  - in_ready falls after 4 pushes.
  - On release, 6 flits stream in order; out_tail on the 6th only.
- Back-to-back packets (L = 2 then L = 1), grant held at 1 → tail of packet 1 at edge e, route_req re-asserted at e+2, packet 2 head at e+3.
- Length wrap: L = 255 → exactly 255 body flits forwarded, then IDLE. No early or late out_tail.
